// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch, load/store and memory-macro signals shared by the port arbiter
interface mem_port_arbiter_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
);
    // Fetch requester
    logic                      if_req;
    logic [ADDRESS_WIDTH-1:0]  if_addr;
    logic [DATA_WIDTH-1:0]     if_rdata;
    logic                      if_ack;

    // Load/store requester
    logic                      d_req;
    logic                      d_we;
    logic [ADDRESS_WIDTH-1:0]  d_addr;
    logic [DATA_WIDTH-1:0]     d_wdata;
    logic [DATA_WIDTH/8-1:0]   d_be;
    logic [DATA_WIDTH-1:0]     d_rdata;
    logic                      d_ack;

    // Memory macro
    logic                      mem_en;
    logic                      mem_we;
    logic [ADDRESS_WIDTH-1:0]  mem_addr;
    logic [DATA_WIDTH-1:0]     mem_wdata;
    logic [DATA_WIDTH/8-1:0]   mem_be;
    logic [DATA_WIDTH-1:0]     mem_rdata;

    // Core pipeline freeze
    logic                      stall;

    // Arbiter side
    modport slave (
        input  if_req, if_addr,
        output if_rdata, if_ack,
        input  d_req, d_we, d_addr, d_wdata, d_be,
        output d_rdata, d_ack,
        output mem_en, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_rdata,
        output stall
    );

    // Core and memory side
    modport master (
        output if_req, if_addr,
        input  if_rdata, if_ack,
        output d_req, d_we, d_addr, d_wdata, d_be,
        input  d_rdata, d_ack,
        input  mem_en, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_rdata,
        input  stall
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port memory arbiter between instruction fetch and load/store
module mem_port_arbiter #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int MEM_LATENCY   = 1,
    parameter int DATA_PRIORITY = 1
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.slave   bus
);
    localparam int              BE_WIDTH = DATA_WIDTH / 8;
    localparam logic [2:0]      LAT_LOAD = 3'(MEM_LATENCY - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_e;
    typedef enum logic {OWNER_FETCH, OWNER_DATA} owner_e;

    state_e                     state_q, state_d;
    owner_e                     owner_q, owner_d;
    owner_e                     last_grant_q, last_grant_d;
    logic [2:0]                 cnt_q, cnt_d;
    logic                       mem_we_q, mem_we_d;
    logic [ADDRESS_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0]      mem_wdata_q, mem_wdata_d;
    logic [BE_WIDTH-1:0]        mem_be_q, mem_be_d;
    logic [DATA_WIDTH-1:0]      if_rdata_q, if_rdata_d;
    logic [DATA_WIDTH-1:0]      d_rdata_q, d_rdata_d;
    logic                       grant_data;
    logic                       if_ack_w;
    logic                       d_ack_w;

    // Pick the winner when the arbiter is free; ties go to data or alternate
    always_comb begin
        grant_data = 1'b0;
        if (bus.d_req && !bus.if_req) begin
            grant_data = 1'b1;
        end else if (bus.d_req && bus.if_req) begin
            if (DATA_PRIORITY != 0) begin
                grant_data = 1'b1;
            end else begin
                grant_data = (last_grant_q == OWNER_FETCH);
            end
        end
    end

    // Access sequencer: grant, issue, wait out the latency, capture, acknowledge
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_be_d     = mem_be_q;
        if_rdata_d   = if_rdata_q;
        d_rdata_d    = d_rdata_q;
        case (state_q)
            IDLE: begin
                if (bus.if_req || bus.d_req) begin
                    state_d = ISSUE;
                    if (grant_data) begin
                        owner_d      = OWNER_DATA;
                        last_grant_d = OWNER_DATA;
                        mem_we_d     = bus.d_we;
                        mem_addr_d   = bus.d_addr;
                        mem_wdata_d  = bus.d_wdata;
                        mem_be_d     = bus.d_be;
                    end else begin
                        // Fetches are always full-word reads
                        owner_d      = OWNER_FETCH;
                        last_grant_d = OWNER_FETCH;
                        mem_we_d     = 1'b0;
                        mem_addr_d   = bus.if_addr;
                        mem_wdata_d  = '0;
                        mem_be_d     = '1;
                    end
                end
            end
            ISSUE: begin
                cnt_d   = LAT_LOAD;
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == 3'd0) begin
                    state_d = ACK;
                    if (owner_q == OWNER_DATA) begin
                        d_rdata_d = bus.mem_rdata;
                    end else begin
                        if_rdata_d = bus.mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops any in-flight response
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= OWNER_FETCH;
            last_grant_q <= OWNER_DATA;
            cnt_q        <= 3'd0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_be_q     <= '0;
            if_rdata_q   <= '0;
            d_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_be_q     <= mem_be_d;
            if_rdata_q   <= if_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    assign if_ack_w      = (state_q == ACK) && (owner_q == OWNER_FETCH);
    assign d_ack_w       = (state_q == ACK) && (owner_q == OWNER_DATA);

    assign bus.if_ack    = if_ack_w;
    assign bus.d_ack     = d_ack_w;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;

    // Write enable is only meaningful alongside the strobe
    assign bus.mem_en    = (state_q == ISSUE);
    assign bus.mem_we    = (state_q == ISSUE) && mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_be    = mem_be_q;

    assign bus.stall     = (bus.if_req && !if_ack_w) || (bus.d_req && !d_ack_w);
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified instruction/data memory between the instruction-fetch path and the load/store path of the RISC-V core.
- Sequences every access through a small FSM: grant, issue, wait for memory latency, capture, acknowledge.
- Drives a stall signal that freezes the PC and pipeline registers while either requester is waiting.
- Sits between the PC/fetch logic, the data-memory interface and the memory macro.

Parameters:
- ADDRESS_WIDTH, 32, byte address width on all ports.
- DATA_WIDTH, 32, word width.
- MEM_LATENCY, 1, cycles from mem_en high to mem_rdata valid; legal range 1..7.
- DATA_PRIORITY, 1, 1 = data always wins a simultaneous request; 0 = round-robin between fetch and data.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- if_req  in  1  fetch request; held high until if_ack.
- if_addr  in  ADDRESS_WIDTH  fetch byte address.
- if_rdata  out  DATA_WIDTH  fetched instruction; valid when if_ack is high.
- if_ack  out  1  one-cycle fetch completion pulse.
- d_req  in  1  data request; held high until d_ack.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDRESS_WIDTH  data byte address.
- d_wdata  in  DATA_WIDTH  store data.
- d_be  in  DATA_WIDTH/8  store byte enables.
- d_rdata  out  DATA_WIDTH  load data; valid when d_ack is high.
- d_ack  out  1  one-cycle data completion pulse.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDRESS_WIDTH  memory byte address.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_be  out  DATA_WIDTH/8  memory byte enables.
- mem_rdata  in  DATA_WIDTH  memory read data.
- stall  out  1  core stall request.

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, ACK.
- Registered state: the owner flag (FETCH/DATA), the latency counter and last_grant.
- IDLE: on the first cycle any request is high, grant it.
  - Capture address, we, wdata and be into the memory-output registers.
  - Set the owner flag and go to ISSUE.
  - Priority when both requests are high:
    - DATA_PRIORITY=1: data wins.
    - DATA_PRIORITY=0: the requester not granted last time wins; last_grant resets to DATA, so fetch wins the first tie.
- ISSUE (exactly one cycle):
  - mem_en=1; mem_we/mem_addr/mem_wdata/mem_be come from the registers.
  - A fetch forces mem_we=0 and mem_be=all ones.
  - Load counter with MEM_LATENCY-1 and go to WAIT.
- WAIT:
  - mem_en=0.
  - Counter decrements each cycle.
  - On the cycle the counter is 0, mem_rdata is captured into the owner's rdata register and the FSM goes to ACK.
  - With MEM_LATENCY=1, WAIT lasts one cycle.
- ACK (exactly one cycle):
  - The owner's ack=1; the other ack=0. Then go to IDLE.
  - No grant is made in the ACK cycle.
  - Result: a request that is still high after its ack is not re-granted until IDLE. Requesters must drop req the cycle after ack.
- Latency: from the grant cycle T in IDLE, ack is high in cycle T+2+MEM_LATENCY. The minimum back-to-back period is MEM_LATENCY+3 cycles.
- Stores follow the same sequence and timing; d_rdata after a store is don't-care.
- rdata registers hold their value until the next capture for the same requester.
- Request withdrawn before ack: the transaction still completes and the ack still pulses; the store is still written.
- Requests arriving while not in IDLE wait; they are never dropped as long as they are held.
- stall = (if_req & ~if_ack) | (d_req & ~d_ack), combinational.
- Reset, including mid-transaction:
  - State goes to IDLE; mem_en, mem_we, if_ack and d_ack go to 0.
  - mem_addr, mem_wdata, mem_be, if_rdata and d_rdata go to 0; last_grant goes to DATA.
  - Any in-flight response is discarded; no ack is produced for it.
- Addresses pass through unmodified; alignment checking is not done here.

Test Plan:
- Single fetch, MEM_LATENCY=1: if_req=1, if_addr=0x0000_0004, memory returns 0x0050_0093 one cycle after mem_en -> mem_en=1 with mem_addr=0x4 and mem_we=0 in T+1; if_ack=1 and if_rdata=0x0050_0093 in T+3; stall=1 in T..T+2 and 0 in T+3.
- Simultaneous requests, DATA_PRIORITY=1: if_req=1 (0x8) and d_req=1 load (0x100, mem word 0xDEAD_BEEF) -> d_ack in T+3 with 0xDEAD_BEEF; fetch granted at T+4 and if_ack in T+7; stall high T..T+6.
- Store: d_req=1, d_we=1, d_addr=0x200, d_wdata=0x1234_5678, d_be=4'b0011 -> ISSUE cycle shows mem_we=1, mem_be=0011, mem_wdata=0x1234_5678; d_ack one cycle; a following load of 0x200 reads back 0x0000_5678 (model pre-zeroed).
- Round-robin, DATA_PRIORITY=0: both requests held continuously for 4 transactions -> grant order FETCH, DATA, FETCH, DATA; acks never overlap.
- MEM_LATENCY=3: a fetch acks at T+5, and rdata matches the memory value presented 3 cycles after mem_en.
- Reset mid-WAIT: assert rst for 1 cycle during WAIT -> the next cycle shows if_ack=0, mem_en=0 and state IDLE; a request still held is re-granted the cycle after rst falls and acks normally.
